load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Multi-beat load/store unit between the core execute stage and a valid/ready data-memory port.
//  Generalises the core's combinational lb/lh/lw/lbu/lhu extraction:
//  - XLEN-parametrised (32/64).
//  - Generates byte enables and lane-shifts store data.
//  - Splits word-crossing misaligned accesses into two aligned beats, or flags them as errors.
//  - Handles memory wait states with a registered FSM.
//  One request outstanding at a time.
// PARAMETERS
//  XLEN              32  data/address width; 32 or 64 (64 adds ld/sd f3=011, lwu f3=110)
//  MISALIGNED_SPLIT  1   1: word-crossing access split into 2 beats; 0: rsp_err, no memory access
//  BE_W              XLEN/8  byte lanes (derived localparam, not overridable)
// PORTS
//  clk         in   1         clock, rising edge
//  reset       in   1         reset, asynchronous, active-high
//  req_valid   in   1         request from core
//  req_ready   out  1         unit idle, request accepted this cycle if req_valid
//  req_we      in   1         1 = store, 0 = load
//  req_funct3  in   3         RISC-V funct3 (size / sign)
//  req_addr    in   XLEN      byte address
//  req_wdata   in   XLEN      store data, LSB-aligned
//  rsp_valid   out  1         one-cycle completion pulse, no backpressure
//  rsp_rdata   out  XLEN      extended load data (0 for stores / errors)
//  rsp_err     out  1         illegal funct3, or crossing access with MISALIGNED_SPLIT=0
//  mem_valid   out  1         memory beat request
//  mem_ready   in   1         memory accepts beat
//  mem_we      out  1         beat is write
//  mem_addr    out  XLEN      BE_W-aligned beat address
//  mem_be      out  BE_W      byte enables
//  mem_wdata   out  XLEN      lane-shifted write data
//  mem_rvalid  in   1         read data valid (>=1 cycle after the mem_valid&mem_ready cycle)
//  mem_rdata   in   XLEN      read data
// BEHAVIOUR
//  - Reset (async): state IDLE; mem_valid=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0;
//    rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 once IDLE.
//    Reset mid-transaction abandons it. mem_rvalid seen in IDLE is ignored.
//  - States: IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, RESP.
//    req_ready = (state==IDLE). The request is captured into registers on acceptance.
//  - Access size S = 1/2/4/8 from f3[1:0]. Offset o = addr % BE_W. Crossing = (o+S > BE_W).
//  - Legal load f3: 000, 001, 010, 100, 101; plus 011, 110 when XLEN=64.
//    Legal store f3: 000, 001, 010; plus 011 when XLEN=64.
//  - IDLE -> RESP, with rsp_err=1 and no mem_valid, for illegal f3 or (Crossing && !MISALIGNED_SPLIT).
//  - Non-crossing access (aligned or misaligned within a word) is a single beat:
//    mem_addr = addr & ~(BE_W-1); mem_be = ((1<<S)-1) << o; mem_wdata = wdata << 8*o.
//  - Crossing access is two beats:
//    - beat0: aligned addr; be = upper BE_W-o lanes; wdata << 8*o.
//    - beat1: aligned addr + BE_W; be = low o+S-BE_W lanes; wdata >> 8*(BE_W-o).
//  - mem_valid and all mem_* fields are held stable until mem_ready.
//  - Load data assembly: beat0 data is stored in a register, then
//    raw = (rd0 >> 8*o) | (rd1 << 8*(BE_W-o)). Raw is truncated to S bytes,
//    sign-extended for f3[2]=0 and zero-extended for f3[2]=1.
//  - Transitions:
//    - B0_REQ & mem_ready: load -> B0_WAIT; store -> (crossing ? B1_REQ : RESP).
//    - B0_WAIT & mem_rvalid -> (crossing ? B1_REQ : RESP).
//    - B1 states behave the same, then go to RESP. RESP -> IDLE.
//  - Minimum latency, acceptance edge to rsp_valid:
//    aligned store 2, aligned load 3, split store 3, split load 5, error 1.
//  - Address wrap: beat1 address is computed modulo 2^XLEN, so a crossing at the top of the
//    address space wraps to 0.
//  - rsp_rdata and rsp_err are valid only with rsp_valid; they are 0 otherwise.
// STRUCTURE
//  - rv_defs.vh (shared): funct3 load/store encodings, FSM state encodings, size decode function.
//  - Sub-module lsu_lane_align (combinational): byte-enable, write-data shift and read
//    merge/extend, parametrised by XLEN. The FSM and registers stay in load_store_unit.
// TESTING
//  1. XLEN=32, lw addr 0x100, mem returns 0x8000_00F0 with 1 wait state
//     -> one beat, be=4'b1111, rsp_rdata=0x8000_00F0, no err.
//  2. lb addr 0x103, rdata 0x80xx_xxxx -> be=4'b1000, rsp_rdata=0xFFFF_FF80;
//     lbu at the same address -> 0x0000_0080.
//  3. sh addr 0x102, wdata 0x0000_BEEF -> mem_be=4'b1100, mem_wdata=0xBEEF_0000, rsp after 2 cycles.
//  4. lw addr 0x0FE, SPLIT=1, beats return 0xAABB_xxxx then 0xxxxx_CCDD
//     -> addrs 0x0FC then 0x100, be 1100/0011, rsp_rdata=0xCCDD_AABB, latency 5.
//  5. Same access with SPLIT=0, and f3=011 with XLEN=32
//     -> rsp_err=1 one cycle after acceptance, mem_valid never asserted.
//  6. Assert reset during B0_WAIT, then issue a late mem_rvalid
//     -> mem_valid drops immediately, no rsp_valid, req_ready=1, the next lw completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state encoding,
// access-size decode and funct3 legality check.
package load_store_unit_pkg;

  // RISC-V load/store funct3 encodings (bit 2 selects zero-extension on loads).
  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3D  = 3'b011;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;
  localparam logic [2:0] Funct3Wu = 3'b110;

  typedef enum logic [2:0] {
    StIdle,
    StB0Req,
    StB0Wait,
    StB1Req,
    StB1Wait,
    StResp
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]: 1, 2, 4 or 8.
  function automatic int unsigned size_bytes(input logic [1:0] size_sel);
    return 32'd1 << size_sel;
  endfunction

  // Legal funct3 for the given direction; is64 enables ld/sd/lwu.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3, input logic is64);
    logic ok;
    if (we) begin
      case (f3)
        Funct3B, Funct3H, Funct3W: ok = 1'b1;
        Funct3D:                   ok = is64;
        default:                   ok = 1'b0;
      endcase
    end else begin
      case (f3)
        Funct3B, Funct3H, Funct3W, Funct3Bu, Funct3Hu: ok = 1'b1;
        Funct3D, Funct3Wu:                             ok = is64;
        default:                                       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane alignment for the load/store unit.
//   offset    : byte offset of the access within a BE_W-byte word
//   size_sel  : funct3[1:0], access size 1/2/4/8 bytes
//   zero_ext  : funct3[2], zero- rather than sign-extend load data
//   wdata     : LSB-aligned store data
//   rd0/rd1   : read data of beat 0 / beat 1
//   be0/be1   : byte enables of beat 0 / beat 1 (be1 is zero for non-crossing accesses)
//   wdata0/1  : lane-shifted write data of beat 0 / beat 1
//   rdata     : merged, truncated and extended load result
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned BE_W = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(BE_W)
) (
  input  logic [OFF_W-1:0] offset,
  input  logic [1:0]       size_sel,
  input  logic             zero_ext,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rd0,
  input  logic [XLEN-1:0]  rd1,
  output logic [BE_W-1:0]  be0,
  output logic [BE_W-1:0]  be1,
  output logic [XLEN-1:0]  wdata0,
  output logic [XLEN-1:0]  wdata1,
  output logic [XLEN-1:0]  rdata
);

  logic [BE_W-1:0]   size_mask;
  logic [2*BE_W-1:0] be_wide;
  logic [2*XLEN-1:0] wd_wide;
  logic [XLEN-1:0]   raw;
  logic [OFF_W+2:0]  bit_shift;
  logic              sign;

  // Shifting into a double-width vector yields both beats at once: the low half is beat 0,
  // the bytes spilling over the word boundary land in the high half for beat 1.
  always_comb begin
    bit_shift = {offset, 3'b000};
    size_mask = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      size_mask[i] = (i < size_bytes(size_sel));
    end
    be_wide = {{BE_W{1'b0}}, size_mask} << offset;
    wd_wide = {{XLEN{1'b0}}, wdata} << bit_shift;
    be0     = be_wide[BE_W-1:0];
    be1     = be_wide[2*BE_W-1:BE_W];
    wdata0  = wd_wide[XLEN-1:0];
    wdata1  = wd_wide[2*XLEN-1:XLEN];
  end

  // For non-crossing accesses the rd1 bytes land above the access size and are discarded.
  always_comb begin
    raw = XLEN'({rd1, rd0} >> bit_shift);
    case (size_sel)
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[XLEN-1];
    endcase
    sign  = sign & ~zero_ext;
    rdata = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      rdata[8*i +: 8] = (i < size_bytes(size_sel)) ? raw[8*i +: 8] : {8{sign}};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-beat load/store unit between the execute stage and a valid/ready data-memory port.
// One request outstanding; word-crossing accesses are split into two aligned beats
// (MISALIGNED_SPLIT=1) or rejected with rsp_err (MISALIGNED_SPLIT=0).
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready : request handshake; req_ready is high while idle
//   req_we/funct3/addr/wdata : request fields, captured on acceptance
//   rsp_valid/rdata/err : one-cycle completion pulse with extended load data / error flag
//   mem_valid/ready/we/addr/be/wdata : memory beat request, held stable until mem_ready
//   mem_rvalid/rdata    : memory read return for load beats
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit MISALIGNED_SPLIT = 1'b1,
  localparam int unsigned BE_W = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(BE_W)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e state_q, state_d;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            err_q;
  logic            cross_q;
  logic [XLEN-1:0] rd0_q;
  logic [XLEN-1:0] rd1_q;

  logic [OFF_W-1:0] req_off;
  logic             req_cross;
  logic             req_err;
  logic [XLEN-1:0]  addr_base;

  logic [BE_W-1:0] be0, be1;
  logic [XLEN-1:0] wdata0, wdata1;
  logic [XLEN-1:0] ld_data;

  // Request decode, evaluated on the raw request so the error path needs no extra state.
  always_comb begin
    req_off   = req_addr[OFF_W-1:0];
    req_cross = (32'(req_off) + size_bytes(req_funct3[1:0])) > BE_W;
    req_err   = !funct3_legal(req_we, req_funct3, XLEN == 64) ||
                (req_cross && !MISALIGNED_SPLIT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) state_d = req_err ? StResp : StB0Req;
      end
      StB0Req: begin
        if (mem_ready) begin
          if (!we_q)        state_d = StB0Wait;
          else if (cross_q) state_d = StB1Req;
          else              state_d = StResp;
        end
      end
      StB0Wait: begin
        if (mem_rvalid) state_d = cross_q ? StB1Req : StResp;
      end
      StB1Req: begin
        if (mem_ready) state_d = we_q ? StResp : StB1Wait;
      end
      StB1Wait: begin
        if (mem_rvalid) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cross_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        cross_q <= req_cross;
      end
      if (state_q == StB0Wait && mem_rvalid) rd0_q <= mem_rdata;
      if (state_q == StB1Wait && mem_rvalid) rd1_q <= mem_rdata;
    end
  end

  load_store_unit_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .offset   (addr_q[OFF_W-1:0]),
    .size_sel (f3_q[1:0]),
    .zero_ext (f3_q[2]),
    .wdata    (wdata_q),
    .rd0      (rd0_q),
    .rd1      (rd1_q),
    .be0      (be0),
    .be1      (be1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .rdata    (ld_data)
  );

  // Memory-side outputs decode from the registered state only, so they stay stable
  // for as long as the beat waits on mem_ready. Beat 1 address wraps modulo 2^XLEN.
  always_comb begin
    addr_base = addr_q & ~XLEN'(BE_W - 1);
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      StB0Req: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_base;
        mem_be    = be0;
        mem_wdata = we_q ? wdata0 : '0;
      end
      StB1Req: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_base + XLEN'(BE_W);
        mem_be    = be1;
        mem_wdata = we_q ? wdata1 : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !we_q && !err_q) ? ld_data : '0;
  end

endmodule
